exec_sequencer: RTL and testbench

Multi-cycle execute controller for the 10-bit, four-register datapath. It accepts one instruction at a time over a start/busy/done handshake and drives the register file's read port pair, receiving its Q0/Q1 read data. An internal ALU computes the result, which is written back through the register file's D/ENW/WRA write port. The block sits directly upstream of the register file (address, enable and write-data side) and downstream of it (read-data side).

---
 rtl/exec_sequencer_if.sv | 33 +++
 rtl/exec_sequencer.sv | 173 +++++++++++++++++
 tb/tb_exec_sequencer.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/exec_sequencer_if.sv
// Bus between the execute sequencer, its instruction source and the register file ports.
// EXEC is a start request sampled only while BUSY is low; a request seen while BUSY is high
// is dropped, and DONE marks the single write-back cycle that completes the instruction.
interface exec_sequencer_if #(
   parameter int WIDTH = 10
);
   logic             EXEC;
   logic [9:0]       INSTR;
   logic [WIDTH-1:0] DIN;
   logic [WIDTH-1:0] Q0;
   logic [WIDTH-1:0] Q1;
   logic [WIDTH-1:0] D;
   logic             ENW;
   logic             ENR0;
   logic             ENR1;
   logic [1:0]       WRA;
   logic [1:0]       RDA0;
   logic [1:0]       RDA1;
   logic             BUSY;
   logic             DONE;
   logic             CF;
   logic             ZF;

   modport master (
      output EXEC, INSTR, DIN, Q0, Q1,
      input  D, ENW, ENR0, ENR1, WRA, RDA0, RDA1, BUSY, DONE, CF, ZF
   );

   modport slave (
      input  EXEC, INSTR, DIN, Q0, Q1,
      output D, ENW, ENR0, ENR1, WRA, RDA0, RDA1, BUSY, DONE, CF, ZF
   );
endinterface

// File: rtl/exec_sequencer.sv
// Four-phase execute controller (IDLE/READ/EXEC/WRITE) for the four-register datapath.
// All state moves on the falling edge of CLKb so it lines up with the register file.
module exec_sequencer #(
   parameter int WIDTH = 10
) (
   input  logic            CLKb,
   input  logic            RSTb,
   exec_sequencer_if.slave bus,
   output logic [1:0]      dbg_state,
   output logic [9:0]      dbg_ir
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_EXEC  = 2'd2,
      S_WRITE = 2'd3
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'b0000;
   localparam logic [3:0] OP_LOAD = 4'b0001;
   localparam logic [3:0] OP_MOV  = 4'b0010;
   localparam logic [3:0] OP_ADD  = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_XOR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1000;
   localparam logic [3:0] OP_INC  = 4'b1001;

   state_t           state;
   logic [9:0]       ir;
   logic [WIDTH-1:0] imm;

   logic [3:0]       op;
   logic [1:0]       rx;
   logic [1:0]       ry;
   logic             writes_rf;

   logic [WIDTH:0]   wide;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cf;
   logic             alu_zf;
   logic             upd_flags;

   assign op        = ir[9:6];
   assign rx        = ir[5:4];
   assign ry        = ir[3:2];
   assign writes_rf = (op != OP_NOP) && (op <= OP_INC);

   assign dbg_state = state;
   assign dbg_ir    = ir;

   // Defaults keep D and the flags unchanged, which covers NOP, illegal opcodes
   // and the flag-holding LOAD/MOV cases without extra enables.
   always_comb begin
      wide      = '0;
      alu_res   = bus.D;
      alu_cf    = bus.CF;
      alu_zf    = bus.ZF;
      upd_flags = 1'b0;
      case (op)
         OP_LOAD: alu_res = imm;
         OP_MOV:  alu_res = bus.Q1;
         OP_ADD: begin
            wide      = {1'b0, bus.Q0} + {1'b0, bus.Q1};
            alu_res   = wide[WIDTH-1:0];
            alu_cf    = wide[WIDTH];
            upd_flags = 1'b1;
         end
         OP_SUB: begin
            // The extra top bit of the difference is the unsigned borrow.
            wide      = {1'b0, bus.Q0} - {1'b0, bus.Q1};
            alu_res   = wide[WIDTH-1:0];
            alu_cf    = wide[WIDTH];
            upd_flags = 1'b1;
         end
         OP_AND: begin
            alu_res   = bus.Q0 & bus.Q1;
            alu_cf    = 1'b0;
            upd_flags = 1'b1;
         end
         OP_OR: begin
            alu_res   = bus.Q0 | bus.Q1;
            alu_cf    = 1'b0;
            upd_flags = 1'b1;
         end
         OP_XOR: begin
            alu_res   = bus.Q0 ^ bus.Q1;
            alu_cf    = 1'b0;
            upd_flags = 1'b1;
         end
         OP_NOT: begin
            alu_res   = ~bus.Q1;
            alu_cf    = 1'b0;
            upd_flags = 1'b1;
         end
         OP_INC: begin
            wide      = {1'b0, bus.Q0} + {{WIDTH{1'b0}}, 1'b1};
            alu_res   = wide[WIDTH-1:0];
            alu_cf    = wide[WIDTH];
            upd_flags = 1'b1;
         end
         default: ;
      endcase
      if (upd_flags) alu_zf = (alu_res == '0);
   end

   // Outputs are set up on the edge that enters each state, so they are clean
   // registers; the async reset clears a pending write before its commit edge.
   always_ff @(negedge CLKb or negedge RSTb) begin
      if (!RSTb) begin
         state    <= S_IDLE;
         ir       <= '0;
         imm      <= '0;
         bus.D    <= '0;
         bus.CF   <= 1'b0;
         bus.ZF   <= 1'b0;
         bus.ENW  <= 1'b0;
         bus.ENR0 <= 1'b0;
         bus.ENR1 <= 1'b0;
         bus.WRA  <= 2'b00;
         bus.RDA0 <= 2'b00;
         bus.RDA1 <= 2'b00;
         bus.BUSY <= 1'b0;
         bus.DONE <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.EXEC) begin
                  state    <= S_READ;
                  ir       <= bus.INSTR;
                  imm      <= bus.DIN;
                  bus.BUSY <= 1'b1;
                  bus.ENR0 <= 1'b1;
                  bus.ENR1 <= 1'b1;
                  bus.RDA0 <= bus.INSTR[5:4];
                  bus.RDA1 <= bus.INSTR[3:2];
               end
            end
            S_READ: begin
               state    <= S_EXEC;
               bus.ENR0 <= 1'b0;
               bus.ENR1 <= 1'b0;
               bus.RDA0 <= 2'b00;
               bus.RDA1 <= 2'b00;
            end
            S_EXEC: begin
               state    <= S_WRITE;
               bus.D    <= alu_res;
               bus.CF   <= alu_cf;
               bus.ZF   <= alu_zf;
               bus.ENW  <= writes_rf;
               bus.WRA  <= rx;
               bus.DONE <= 1'b1;
            end
            S_WRITE: begin
               state    <= S_IDLE;
               bus.ENW  <= 1'b0;
               bus.WRA  <= 2'b00;
               bus.DONE <= 1'b0;
               bus.BUSY <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // ry is only needed on the capture edge, where it is taken straight from INSTR.
   logic unused_ry;
   assign unused_ry = ^ry;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer: a register-file model feeds Q0/Q1 and a monitor
// checks every DONE cycle against hand-computed write-back values queued at issue time.
module tb_exec_sequencer;

   typedef struct packed {
      logic [9:0] d;
      logic       cf;
      logic       zf;
      logic       enw;
      logic [1:0] wra;
   } exp_t;

   logic       CLKb;
   logic       RSTb;
   logic [1:0] dbg_state;
   logic [9:0] dbg_ir;

   exec_sequencer_if #(.WIDTH(10)) bus ();

   exec_sequencer #(.WIDTH(10)) dut (
      .CLKb      (CLKb),
      .RSTb      (RSTb),
      .bus       (bus),
      .dbg_state (dbg_state),
      .dbg_ir    (dbg_ir)
   );

   // clock / reset
   initial begin
      CLKb = 1'b1;
      forever #5 CLKb = ~CLKb;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   // register file model, falling-edge like the real one
   logic [9:0] rf [4] = '{default: 10'h000};

   always @(negedge CLKb) begin
      if (bus.ENR0) bus.Q0 <= rf[bus.RDA0];
      if (bus.ENR1) bus.Q1 <= rf[bus.RDA1];
      if (bus.ENW)  rf[bus.WRA] <= bus.D;
   end

   // scoreboard
   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   always @(posedge CLKb) begin
      if (RSTb === 1'b1 && bus.DONE === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_done: got DONE=1 expected no pending instruction");
         end else begin
            mon_e = exp_q.pop_front();
            check("wb_d",   bus.D,   mon_e.d);
            check("wb_cf",  bus.CF,  mon_e.cf);
            check("wb_zf",  bus.ZF,  mon_e.zf);
            check("wb_enw", bus.ENW, mon_e.enw);
            check("wb_wra", bus.WRA, mon_e.wra);
         end
      end
   end

   // driver: called on a rising edge; returns on the rising edge after the write edge
   task automatic run_instr(input logic [9:0] instr, input logic [9:0] din, input logic [9:0] d,
                            input logic cf, input logic zf, input logic enw, input logic [1:0] wra);
      exp_t e;
      e.d = d; e.cf = cf; e.zf = zf; e.enw = enw; e.wra = wra;
      exp_q.push_back(e);
      bus.EXEC  = 1'b1;
      bus.INSTR = instr;
      bus.DIN   = din;
      @(negedge CLKb);
      @(posedge CLKb);
      bus.EXEC  = 1'b0;
      bus.INSTR = 10'($urandom_range(0, 1023));
      bus.DIN   = 10'($urandom_range(0, 1023));
      check("read_busy",  bus.BUSY, 1);
      check("read_enr0",  bus.ENR0, 1);
      check("read_enr1",  bus.ENR1, 1);
      check("read_rda0",  bus.RDA0, instr[5:4]);
      check("read_rda1",  bus.RDA1, instr[3:2]);
      check("read_enw",   bus.ENW,  0);
      check("read_state", dbg_state, 1);
      check("ir_capture", dbg_ir,   instr);
      @(negedge CLKb);
      @(posedge CLKb);
      check("exec_enr0",  bus.ENR0, 0);
      check("exec_busy",  bus.BUSY, 1);
      check("exec_done",  bus.DONE, 0);
      @(negedge CLKb);
      @(posedge CLKb);
      check("write_state", dbg_state, 3);
      @(negedge CLKb);
      @(posedge CLKb);
      check("idle_busy", bus.BUSY, 0);
      check("idle_done", bus.DONE, 0);
      check("idle_enw",  bus.ENW,  0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_busy"},  bus.BUSY, 0);
      check({tag, "_done"},  bus.DONE, 0);
      check({tag, "_enw"},   bus.ENW,  0);
      check({tag, "_enr"},   {bus.ENR0, bus.ENR1}, 0);
      check({tag, "_addr"},  {bus.WRA, bus.RDA0, bus.RDA1}, 0);
      check({tag, "_d"},     bus.D,    0);
      check({tag, "_flags"}, {bus.CF, bus.ZF}, 0);
      check({tag, "_state"}, dbg_state, 0);
      check({tag, "_ir"},    dbg_ir,   0);
   endtask

   // directed program: instr, din, expected D, CF, ZF, ENW, WRA
   localparam int N_PROG = 16;
   logic [9:0] p_instr [N_PROG] = '{
      10'b0001010000, 10'b0001100000, 10'b0011011000, 10'b0001000000,
      10'b0001110000, 10'b0100001100, 10'b0010010000, 10'b0101101100,
      10'b0111111100, 10'b0110110000, 10'b1000101100, 10'b1001110000,
      10'b1001110000, 10'b0100011000, 10'b1111000000, 10'b0000110100};
   logic [9:0] p_din [N_PROG] = '{
      10'h3FF, 10'h001, 10'h155, 10'h005, 10'h007, 10'h2A2, 10'h111, 10'h0F0,
      10'h3C3, 10'h222, 10'h333, 10'h044, 10'h055, 10'h066, 10'h3FF, 10'h123};
   logic [9:0] p_d [N_PROG] = '{
      10'h3FF, 10'h001, 10'h000, 10'h005, 10'h007, 10'h3FE, 10'h3FE, 10'h001,
      10'h000, 10'h3FE, 10'h001, 10'h3FF, 10'h000, 10'h3FD, 10'h3FD, 10'h3FD};
   logic       p_cf  [N_PROG] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
   logic       p_zf  [N_PROG] = '{0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
   logic       p_enw [N_PROG] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
   logic [1:0] p_wra [N_PROG] = '{1, 2, 1, 0, 3, 0, 1, 2, 3, 3, 2, 3, 3, 1, 0, 3};

   // EXEC held high; only slots 0, 4 and 8 may be captured
   logic [9:0] h_instr [12] = '{
      10'b0001000000, 10'b1001000000, 10'b0111000000, 10'b0011000100,
      10'b0001010000, 10'b1000000000, 10'b0010000100, 10'b0001000000,
      10'b0011000100, 10'b0001000000, 10'b1001000000, 10'b0100000100};
   logic [9:0] h_din [12] = '{
      10'h155, 10'h000, 10'h000, 10'h000, 10'h2AA, 10'h000,
      10'h000, 10'h000, 10'h3AA, 10'h123, 10'h000, 10'h000};

   initial begin
      RSTb      = 1'b0;
      bus.EXEC  = 1'b1;
      bus.INSTR = 10'b0001010000;
      bus.DIN   = 10'h3FF;
      #2;
      check_reset_values("rst_early");
      #6;
      check_reset_values("rst_late");
      @(posedge CLKb);
      RSTb = 1'b1;

      for (int i = 0; i < N_PROG; i++)
         run_instr(p_instr[i], p_din[i], p_d[i], p_cf[i], p_zf[i], p_enw[i], p_wra[i]);

      exp_q.push_back(exp_t'{d: 10'h155, cf: 1'b0, zf: 1'b0, enw: 1'b1, wra: 2'd0});
      exp_q.push_back(exp_t'{d: 10'h2AA, cf: 1'b0, zf: 1'b0, enw: 1'b1, wra: 2'd1});
      exp_q.push_back(exp_t'{d: 10'h3FF, cf: 1'b0, zf: 1'b0, enw: 1'b1, wra: 2'd0});
      bus.EXEC = 1'b1;
      for (int c = 0; c < 12; c++) begin
         bus.INSTR = h_instr[c];
         bus.DIN   = h_din[c];
         @(negedge CLKb);
         @(posedge CLKb);
         check("hold_busy", bus.BUSY, ((c % 4) != 3) ? 1 : 0);
      end
      bus.EXEC = 1'b0;

      // ADD R1,R2 aborted by reset in WRITE, ahead of its commit edge
      bus.EXEC  = 1'b1;
      bus.INSTR = 10'b0011011000;
      @(negedge CLKb);
      @(posedge CLKb);
      bus.EXEC = 1'b0;
      @(negedge CLKb);
      @(negedge CLKb);
      #1;
      check("abort_pre_enw",   bus.ENW, 1);
      check("abort_pre_state", dbg_state, 3);
      #1;
      RSTb = 1'b0;
      #1;
      check_reset_values("abort");
      @(posedge CLKb);
      RSTb = 1'b1;

      run_instr(10'b0010110100, 10'h000, 10'h2AA, 1'b0, 1'b0, 1'b1, 2'd3);
      run_instr(10'b0010100000, 10'h000, 10'h3FF, 1'b0, 1'b0, 1'b1, 2'd2);

      repeat (3) @(posedge CLKb);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
